// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for a small ARM-like datapath.
//
// Ports:
//   clk        - sole clock; all state updates on the rising edge
//   reset      - asynchronous, active-low reset
//   Instr      - Instr[31:12] from the instruction register
//                (bit 19:16 cond, 15:14 op, 13:8 funct, 3:0 rd)
//   ALUFlags   - {N,Z,C,V} produced by the ALU in the current cycle
//   PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ALUSrcA, ByteLoad
//              - single-bit datapath controls
//   ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl
//              - two-bit datapath selects
//   State      - current FSM state, for debug
//
// State      | meaning
// -----------+--------------------------------------------------
// FETCH    0 | fetch instruction, PC <= PC+4
// DECODE   1 | read registers, latch condition result
// MEMADR   2 | compute memory address
// MEMRD    3 | read data memory
// MEMWB    4 | write loaded data back
// MEMWR    5 | write data memory
// EXECUTER 6 | ALU op, register operand
// EXECUTEI 7 | ALU op, immediate operand
// ALUWB    8 | write ALU result back
// BRANCH   9 | branch target into PC

module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        ALUSrcA,
    output logic        ByteLoad,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t      state_q;
    logic [3:0]  flags_q;
    logic        condex_q;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        is_addsub;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign is_addsub = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);

    function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = cy;
            4'b0011: cond_ex = ~cy;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = cy & ~z;
            4'b1001: cond_ex = ~(cy & ~z);
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_dec(input logic [3:0] cmd);
        case (cmd)
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b0001: alu_dec = 2'b11;
            default: alu_dec = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b1;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    condex_q <= cond_ex(cond, flags_q);
                    case (op)
                        2'b01:   state_q <= S_MEMADR;
                        2'b00:   state_q <= funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b10:   state_q <= S_BRANCH;
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXECUTER, S_EXECUTEI: begin
                    state_q <= S_ALUWB;
                    // Flags only move for executed, flag-setting instructions;
                    // logical ops leave carry/overflow alone.
                    if (condex_q && funct[0]) begin
                        flags_q[3:2] <= ALUFlags[3:2];
                        if (is_addsub)
                            flags_q[1:0] <= ALUFlags[1:0];
                    end
                end
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    logic pc_write_c, ir_write_c, reg_write_c, mem_write_c;

    always_comb begin
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ByteLoad    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = 2'b00;
        ImmSrc      = op;
        RegSrc      = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMRD:    AdrSrc  = 1'b1;
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                mem_write_c = condex_q;
            end
            S_EXECUTER: ALUControl = alu_dec(funct[4:1]);
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct[4:1]);
            end
            S_MEMWB, S_ALUWB: begin
                ResultSrc = (state_q == S_MEMWB) ? 2'b01 : 2'b00;
                ByteLoad  = (state_q == S_MEMWB) ? funct[2] : 1'b0;
                // A write to R15 is a jump: route it to the PC instead.
                if (rd == 4'hf)
                    pc_write_c  = condex_q;
                else
                    reg_write_c = condex_q;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                pc_write_c = condex_q;
            end
            default: ;
        endcase
    end

    // Architectural strobes are killed by reset without waiting for a clock.
    assign PCWrite  = pc_write_c  & reset;
    assign IRWrite  = ir_write_c  & reset;
    assign RegWrite = reg_write_c & reset;
    assign MemWrite = mem_write_c & reset;
    assign State    = state_q;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: Instr  input  20  Instr[31:12], driven from the instruction register.
REQ-004 SHALL have port: ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-005 SHALL have port: PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ALUSrcA, ByteLoad  output  1 each.
REQ-006 SHALL have port: ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl  output  2 each.
REQ-007 SHALL have port: State  output  4  current FSM state, for debug.

Function
REQ-008 SHALL implement an FSM with these State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-009 SHALL use these transitions:
- FETCH->DECODE.
- DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECUTER; Op=00 with Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH, with no writes.
- MEMADR: Funct[0]=1->MEMRD, else MEMWR.
- MEMRD->MEMWB.
- EXECUTER/EXECUTEI->ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-010 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00 and PCWrite=1 (PC<=PC+4).
REQ-011 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (produces PC+8 for R15 reads); no write strobes.
REQ-012 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=00.
REQ-013 MEMRD SHALL drive AdrSrc=1; MEMWR SHALL drive AdrSrc=1 and MemWrite=condex_q.
REQ-014 MEMWB SHALL drive ResultSrc=01, ByteLoad=Funct[2], and the writeback rule in REQ-019.
REQ-015 EXECUTER SHALL drive ALUSrcA=0, ALUSrcB=00; EXECUTEI SHALL drive ALUSrcA=0, ALUSrcB=01; both SHALL use the ALU decode in REQ-017.
REQ-016 ALUWB SHALL drive ResultSrc=00 and the writeback rule in REQ-019; BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10 and PCWrite=condex_q.
REQ-017 ALU decode SHALL map Funct[4:1] as follows: 0100->00 (ADD), 0010->01 (SUB), 0000->10 (AND), 0001->11 (EOR), any other value->00. ALUControl SHALL be 00 in every state not named in REQ-015.
REQ-018 ImmSrc SHALL equal Op in all states. RegSrc[0] SHALL be (Op==10). RegSrc[1] SHALL be (Op==01 & Funct[0]==0).
REQ-019 Writeback rule in MEMWB/ALUWB: if Rd=15, PCWrite=condex_q and RegWrite=0; otherwise RegWrite=condex_q and PCWrite=0.
REQ-020 condex_q SHALL be a flop loaded at the end of DECODE with CondEx(Instr[31:28], Flags) and held until the next DECODE. Cond=1111 SHALL evaluate false.
REQ-021 Flags SHALL be a 4-bit register updated only at the end of EXECUTER/EXECUTEI when condex_q=1:
- N,Z <= ALUFlags[3:2] if S (Funct[0]) = 1.
- C,V <= ALUFlags[1:0] if S=1 and the op is ADD or SUB.
REQ-022 All strobes not named for a state SHALL be 0. Every output SHALL be a function of State, Instr and condex_q only, with no combinational path from ALUFlags.
REQ-023 Latency: DP = 4 cycles, LDR/LDRB = 5, STR = 4, B = 3, Op=11 = 2.

Reset
REQ-024 While reset=0: State=FETCH, Flags=0000, condex_q=1, and PCWrite, IRWrite, RegWrite, MemWrite forced 0 immediately (asynchronously), including mid-instruction.
REQ-025 After reset deasserts, the first rising edge SHALL execute FETCH.

Verification
REQ-026 ADD R2,R0,#5 (E2802005) -> States 0,1,7,8; ALUControl=00 in state 7; RegWrite=1 only in state 8; PCWrite=1 only in state 0.
REQ-027 LDRB R3,[R0,#4] (E5D03004) -> States 0,1,2,3,4; ByteLoad=1 and ResultSrc=01 in state 4; MemWrite=0 throughout.
REQ-028 STR R2,[R0,#8] (E5802008) -> States 0,1,2,5; MemWrite=1 and AdrSrc=1 in state 5 only; RegSrc=10.
REQ-029 SUBS R1,R1,R1 (E0511001) with ALUFlags=0110 in EXECUTER, then BEQ (0A000002):
- BRANCH asserts PCWrite=1.
- Repeating with ALUFlags=0010 gives Z=0 and PCWrite=0 in BRANCH.
REQ-030 EORNES R4,R4,R4 (10344004) with Flags.Z=1 -> RegWrite=0 in ALUWB; Flags unchanged despite ALUFlags=0100.
REQ-031 reset driven 0 during MEMWR -> MemWrite=0 and State=0 within the same cycle; Flags=0000.
